// File: rtl/idex_stage.sv
// ---------------------------------------------------------------------------
// idex_stage
//
// Flow-controlled ID/EX pipeline stage. It sits between decode and the
// ALU/execute stage and carries the decode payload (PC, both register
// operands, the load/store/jal address, the auipc/lui immediate and the two
// ALU source selects).
//
// A two-entry skid buffer is used so that InReady comes straight from a
// register. This means there is no combinational path from OutReady to
// InReady.
//
// Other features:
//   - A synchronous flush discards all held entries.
//   - When BUBBLE_ZERO is set, the output data is cleared whenever the
//     stage goes empty.
//   - A saturating counter records the number of stalled cycles.
//
// Ports
//   CLK, RSTn           clock (rising edge) and asynchronous active-low reset
//   Flush               synchronous flush; next state is empty
//   InValid / InReady   upstream handshake (InReady is registered)
//   In*                 decode payload
//   OutValid / OutReady downstream handshake
//   PC .. ALUSourceB    registered payload presented to execute
//   StallCount          cycles with OutValid && !OutReady, saturating
// ---------------------------------------------------------------------------
module idex_stage #(
    parameter int XLEN        = 32,
    parameter int SRCA_W      = 2,
    parameter int SRCB_W      = 3,
    parameter int CNT_W       = 16,
    parameter int BUBBLE_ZERO = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [XLEN-1:0]   InPC,
    input  logic [XLEN-1:0]   Inrs1val,
    input  logic [XLEN-1:0]   Inrs2val,
    input  logic [XLEN-1:0]   InLoadStoreOrjalAddress,
    input  logic [XLEN-1:0]   InauipcOrlui,
    input  logic [SRCA_W-1:0] InALUSourceA,
    input  logic [SRCB_W-1:0] InALUSourceB,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [XLEN-1:0]   PC,
    output logic [XLEN-1:0]   rs1val,
    output logic [XLEN-1:0]   rs2val,
    output logic [XLEN-1:0]   LoadStoreOrjalAddress,
    output logic [XLEN-1:0]   auipcOrlui,
    output logic [SRCA_W-1:0] ALUSourceA,
    output logic [SRCB_W-1:0] ALUSourceB,
    output logic [CNT_W-1:0]  StallCount
);

    localparam int PW = 5 * XLEN + SRCA_W + SRCB_W;

    // Bit 0 of the state encoding is the main-register valid bit (mv).
    // Bit 1 is the skid-register valid bit (sv).
    // The encoding 2'b10 (skid valid with main empty) is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    main_q, main_d;
    logic [PW-1:0]    skid_q, skid_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic [PW-1:0] inPayload;
    logic          mainValid;
    logic          skidValid;
    logic          accept;
    logic          drain;

    assign inPayload = {InPC, Inrs1val, Inrs2val, InLoadStoreOrjalAddress,
                        InauipcOrlui, InALUSourceA, InALUSourceB};

    assign mainValid = state_q[0];
    assign skidValid = state_q[1];
    assign InReady   = ~skidValid;
    assign OutValid  = mainValid;
    assign accept    = InValid & ~skidValid;
    assign drain     = mainValid & OutReady;

    assign {PC, rs1val, rs2val, LoadStoreOrjalAddress, auipcOrlui,
            ALUSourceA, ALUSourceB} = main_q;
    assign StallCount = stallCnt_q;

    // Next-state logic for the skid buffer.
    // Flush overrides both the state and the main data.
    // Skid data is left untouched by a flush: it is never visible on the
    // outputs, and it is overwritten before it can be promoted to main.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = inPayload;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_d = inPayload;
                end else if (accept) begin
                    skid_d  = inPayload;
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                    if (BUBBLE_ZERO != 0) begin
                        main_d = '0;
                    end
                end
            end
            FULL: begin
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (Flush) begin
            state_d = EMPTY;
            if (BUBBLE_ZERO != 0) begin
                main_d = '0;
            end
        end
    end

    // The stall counter saturates at all-ones rather than wrapping.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (mainValid && !OutReady && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_idex_stage.sv
// ---------------------------------------------------------------------------
// tb_idex_stage
//
// Self-checking bench for idex_stage (XLEN=32, CNT_W=4, BUBBLE_ZERO=1).
//
// A FIFO reference model (at most two entries) acts as the scoreboard:
//   - entries are pushed when the model says the stage accepts;
//   - the head entry is compared against the outputs while it is presented;
//   - the head entry is popped on a drain.
// ---------------------------------------------------------------------------
module tb_idex_stage;

    localparam int XLEN   = 32;
    localparam int SRCA_W = 2;
    localparam int SRCB_W = 3;
    localparam int CNT_W  = 4;
    localparam int PW     = 5 * XLEN + SRCA_W + SRCB_W;

    typedef logic [PW-1:0] entry_t;

    logic              CLK;
    logic              RSTn;
    logic              Flush;
    logic              InValid;
    logic              InReady;
    logic [XLEN-1:0]   InPC, Inrs1val, Inrs2val, InLoadStoreOrjalAddress, InauipcOrlui;
    logic [SRCA_W-1:0] InALUSourceA;
    logic [SRCB_W-1:0] InALUSourceB;
    logic              OutValid;
    logic              OutReady;
    logic [XLEN-1:0]   PC, rs1val, rs2val, LoadStoreOrjalAddress, auipcOrlui;
    logic [SRCA_W-1:0] ALUSourceA;
    logic [SRCB_W-1:0] ALUSourceB;
    logic [CNT_W-1:0]  StallCount;

    entry_t         modelQ[$];
    int             modelCnt;
    int             assertCount;
    int             failCount;
    entry_t         e;
    logic [XLEN-1:0] noPc;

    idex_stage #(
        .XLEN(XLEN), .SRCA_W(SRCA_W), .SRCB_W(SRCB_W),
        .CNT_W(CNT_W), .BUBBLE_ZERO(1)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .InPC(InPC), .Inrs1val(Inrs1val), .Inrs2val(Inrs2val),
        .InLoadStoreOrjalAddress(InLoadStoreOrjalAddress),
        .InauipcOrlui(InauipcOrlui),
        .InALUSourceA(InALUSourceA), .InALUSourceB(InALUSourceB),
        .OutValid(OutValid), .OutReady(OutReady),
        .PC(PC), .rs1val(rs1val), .rs2val(rs2val),
        .LoadStoreOrjalAddress(LoadStoreOrjalAddress),
        .auipcOrlui(auipcOrlui),
        .ALUSourceA(ALUSourceA), .ALUSourceB(ALUSourceB),
        .StallCount(StallCount)
    );

    // Free-running clock: 10 ns period, rising edge is the active edge.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Builds a deterministic payload in which every field is derived from
    // the PC. A misrouted field is therefore visible in the comparison.
    function automatic entry_t makeEntry(input logic [31:0] pc);
        logic [31:0] r1, r2, ad, ui;
        r1 = pc ^ 32'hDEAD_0000;
        r2 = pc + 32'h0000_1111;
        ad = ~pc;
        ui = {pc[15:0], pc[31:16]};
        return {pc, r1, r2, ad, ui, pc[3:2], pc[4:2]};
    endfunction

    // Single comparison point: counts the comparison and reports a
    // mismatch.
    task automatic checkOutput(input string tag, input logic [191:0] obs,
                               input logic [191:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares all DUT outputs against the reference model. When the model
    // is empty, bubble zeroing means the payload must read as zero.
    task automatic checkAll(input string tag);
        entry_t obsPayload;
        entry_t expPayload;
        obsPayload = {PC, rs1val, rs2val, LoadStoreOrjalAddress, auipcOrlui,
                      ALUSourceA, ALUSourceB};
        expPayload = (modelQ.size() > 0) ? modelQ[0] : '0;
        checkOutput({tag, ".OutValid"}, 192'(OutValid), 192'(modelQ.size() > 0));
        checkOutput({tag, ".InReady"}, 192'(InReady), 192'(modelQ.size() < 2));
        checkOutput({tag, ".StallCount"}, 192'(StallCount), 192'(modelCnt));
        checkOutput({tag, ".PC"}, 192'(PC), 192'(expPayload[PW-1 -: XLEN]));
        checkOutput({tag, ".payload"}, 192'(obsPayload), 192'(expPayload));
    endtask

    // Drives one cycle of stimulus. The call is made #1 after a rising edge.
    // The sequence is:
    //   1. drive the inputs;
    //   2. check the current outputs;
    //   3. clock the edge and advance the model.
    task automatic applyStimulus(input string tag, input logic v, input entry_t ent,
                                 input logic ordy, input logic fl);
        logic acc, drn, stl;
        InValid  = v;
        {InPC, Inrs1val, Inrs2val, InLoadStoreOrjalAddress, InauipcOrlui,
         InALUSourceA, InALUSourceB} = ent;
        OutReady = ordy;
        Flush    = fl;
        checkAll(tag);
        acc = v && (modelQ.size() < 2);
        drn = (modelQ.size() > 0) && ordy;
        stl = (modelQ.size() > 0) && !ordy;
        @(posedge CLK);
        if (stl && modelCnt != 15) modelCnt++;
        if (fl) begin
            modelQ.delete();
        end else begin
            if (drn) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(ent);
        end
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        modelCnt    = 0;
        noPc        = 32'h0;
        RSTn        = 1'b0;
        Flush       = 1'b0;
        InValid     = 1'b0;
        OutReady    = 1'b0;
        {InPC, Inrs1val, Inrs2val, InLoadStoreOrjalAddress, InauipcOrlui,
         InALUSourceA, InALUSourceB} = '0;
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // Reset state, then a stream of three entries with OutReady held high.
        applyStimulus("stream0", 1'b1, makeEntry(32'h100), 1'b1, 1'b0);
        applyStimulus("stream1", 1'b1, makeEntry(32'h104), 1'b1, 1'b0);
        applyStimulus("stream2", 1'b1, makeEntry(32'h108), 1'b1, 1'b0);
        applyStimulus("stream3", 1'b0, makeEntry(noPc), 1'b1, 1'b0);
        applyStimulus("stream4", 1'b0, makeEntry(noPc), 1'b1, 1'b0);

        // Backpressure: fill the skid buffer, try to push a third entry,
        // then release OutReady and drain in order.
        applyStimulus("bp0", 1'b1, makeEntry(32'h200), 1'b0, 1'b0);
        applyStimulus("bp1", 1'b1, makeEntry(32'h204), 1'b0, 1'b0);
        applyStimulus("bp2", 1'b1, makeEntry(32'h208), 1'b0, 1'b0);
        applyStimulus("bp3", 1'b1, makeEntry(32'h208), 1'b0, 1'b0);
        applyStimulus("bp4", 1'b1, makeEntry(32'h208), 1'b1, 1'b0);
        applyStimulus("bp5", 1'b1, makeEntry(32'h208), 1'b1, 1'b0);
        applyStimulus("bp6", 1'b0, makeEntry(noPc), 1'b1, 1'b0);
        applyStimulus("bp7", 1'b0, makeEntry(noPc), 1'b1, 1'b0);
        applyStimulus("bp8", 1'b0, makeEntry(noPc), 1'b1, 1'b0);

        // Flush while FULL. The offered 0x308 is discarded, and a new entry
        // is accepted right after the flush.
        applyStimulus("fl0", 1'b1, makeEntry(32'h300), 1'b0, 1'b0);
        applyStimulus("fl1", 1'b1, makeEntry(32'h304), 1'b0, 1'b0);
        applyStimulus("fl2", 1'b1, makeEntry(32'h308), 1'b0, 1'b1);
        applyStimulus("fl3", 1'b1, makeEntry(32'h30C), 1'b0, 1'b0);
        applyStimulus("fl4", 1'b1, makeEntry(32'h310), 1'b1, 1'b1);
        applyStimulus("fl5", 1'b0, makeEntry(noPc), 1'b1, 1'b0);

        // Simultaneous accept and drain in ONE. The skid buffer stays
        // unused, so InReady remains high.
        applyStimulus("ad0", 1'b1, makeEntry(32'h400), 1'b0, 1'b0);
        applyStimulus("ad1", 1'b1, makeEntry(32'h404), 1'b1, 1'b0);
        applyStimulus("ad2", 1'b0, makeEntry(noPc), 1'b1, 1'b0);
        applyStimulus("ad3", 1'b0, makeEntry(noPc), 1'b1, 1'b0);

        // Counter saturation: hold OutValid with OutReady low for 20 cycles.
        applyStimulus("sat0", 1'b1, makeEntry(32'h500), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("sat", 1'b0, makeEntry(noPc), 1'b0, 1'b0);
        end
        checkOutput("satValue", 192'(StallCount), 192'(15));
        applyStimulus("sat1", 1'b0, makeEntry(noPc), 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 80; i++) begin
            e = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                 SRCA_W'($urandom()), SRCB_W'($urandom())};
            applyStimulus("rnd", 1'($urandom_range(0, 3) != 0), e,
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-stall. Fill to FULL, then drop RSTn
        // between edges and check the outputs immediately.
        applyStimulus("ar0", 1'b1, makeEntry(32'h600), 1'b0, 1'b0);
        applyStimulus("ar1", 1'b1, makeEntry(32'h604), 1'b0, 1'b0);
        applyStimulus("ar2", 1'b0, makeEntry(noPc), 1'b0, 1'b0);
        checkOutput("arFullReady", 192'(InReady), 192'(0));
        InValid  = 1'b0;
        OutReady = 1'b0;
        #2;
        RSTn = 1'b0;
        #1;
        modelQ.delete();
        modelCnt = 0;
        checkAll("asyncReset");
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // Normal operation resumes after reset.
        applyStimulus("post0", 1'b1, makeEntry(32'h700), 1'b1, 1'b0);
        applyStimulus("post1", 1'b1, makeEntry(32'h704), 1'b1, 1'b0);
        applyStimulus("post2", 1'b0, makeEntry(noPc), 1'b1, 1'b0);
        applyStimulus("post3", 1'b0, makeEntry(noPc), 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
